// File: rtl/reduce_rd_sequencer_if.sv
// Handshake/bus bundle between the reduce read sequencer, the mux it drives,
// and the downstream consumer of the captured words.
interface reduce_rd_sequencer_if #(
  parameter int unsigned NUM   = 8,
  parameter int unsigned WIDTH = 5,
  parameter int unsigned IDXW  = $clog2(NUM)
);
  logic             start_i;
  logic [NUM-1:0]   mask_i;
  logic [NUM-1:0]   rd_o;
  logic [WIDTH-1:0] data_i;
  logic [WIDTH-1:0] data_o;
  logic [IDXW-1:0]  idx_o;
  logic             valid_o;
  logic             ready_i;
  logic             busy_o;
  logic             done_o;

  modport slave (
    input  start_i, mask_i, data_i, ready_i,
    output rd_o, data_o, idx_o, valid_o, busy_o, done_o
  );

  modport master (
    output start_i, mask_i, data_i, ready_i,
    input  rd_o, data_o, idx_o, valid_o, busy_o, done_o
  );
endinterface

// File: rtl/reduce_rd_sequencer.sv
// Walks a latched lane mask lowest-first, strobing one mux lane per beat and
// streaming each captured word downstream over valid/ready, then pulses done.
module reduce_rd_sequencer #(
  parameter int unsigned NUM   = 8,
  parameter int unsigned WIDTH = 5,
  parameter int unsigned IDXW  = $clog2(NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  reduce_rd_sequencer_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [NUM-1:0]   pending_q, pending_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic             can_load_c;
  logic [NUM-1:0]   low_c;
  logic [NUM-1:0]   rd_c;
  logic [IDXW-1:0]  rd_idx_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      data_q    <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    data_d     = data_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    rd_idx_c   = '0;

    // A new word may be loaded only when the output slot is empty or draining.
    can_load_c = !valid_q || bus.ready_i;
    low_c      = pending_q & (~pending_q + NUM'(1));
    rd_c       = (state_q == RUN && can_load_c && pending_q != '0) ? low_c : '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (rd_c[i]) rd_idx_c = IDXW'(i);
    end

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          pending_d = bus.mask_i;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (rd_c != '0) begin
          data_d    = bus.data_i;
          idx_d     = rd_idx_c;
          valid_d   = 1'b1;
          pending_d = pending_q & ~rd_c;
        end else if (valid_q && bus.ready_i) begin
          valid_d = 1'b0;
        end
        if (pending_q == '0 && can_load_c) begin
          state_d = IDLE;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rd_o    = rd_c;
  assign bus.data_o  = data_q;
  assign bus.idx_o   = idx_q;
  assign bus.valid_o = valid_q;
  assign bus.busy_o  = (state_q == RUN);
  assign bus.done_o  = done_q;

endmodule

// File: tb/tb_reduce_rd_sequencer.sv
// Scoreboard bench for reduce_rd_sequencer: a mux model answers rd_o, the
// driver queues expected words per scan, a monitor pops and compares them.
module tb_reduce_rd_sequencer;
  localparam int unsigned NUM   = 8;
  localparam int unsigned WIDTH = 5;
  localparam int unsigned IDXW  = $clog2(NUM);

  typedef struct {
    int unsigned idx;
    int unsigned data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t        exp_q[$];
  int          exp_done = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          stall_cnt = 0;
  int          xfer_cyc[$];
  logic [31:0] rd_log[$];
  int          rd_cyc[$];

  logic [WIDTH-1:0] lane_data [NUM];

  logic             prev_stall = 1'b0;
  logic             prev_done  = 1'b0;
  logic [WIDTH-1:0] prev_data  = '0;
  logic [IDXW-1:0]  prev_idx   = '0;
  exp_t             mon_e;

  reduce_rd_sequencer_if #(.NUM(NUM), .WIDTH(WIDTH)) bus ();

  reduce_rd_sequencer #(.NUM(NUM), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Priority mux model: returns the data of the lowest strobed lane.
  always_comb begin
    bus.data_i = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (bus.rd_o[i]) bus.data_i = lane_data[i];
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: a scan of mask yields its set lanes in ascending order, then one done.
  task automatic expect_scan(input logic [NUM-1:0] mask);
    for (int i = 0; i < NUM; i++) begin
      if (mask[i]) exp_q.push_back('{idx: i, data: 32'(lane_data[i])});
    end
    exp_done++;
  endtask

  task automatic clear_logs();
    xfer_cyc.delete();
    rd_log.delete();
    rd_cyc.delete();
    stall_cnt = 0;
  endtask

  task automatic do_start(input logic [NUM-1:0] mask, output int p);
    bus.start_i = 1'b1;
    bus.mask_i  = mask;
    p = cyc;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input bit rnd);
    bit found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.done_o) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (rnd) bus.ready_i = ($urandom_range(0, 3) != 0);
    end
    if (!found) check("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.ready_i = 1'b1;
  endtask

  task automatic set_lanes_random();
    for (int i = 0; i < NUM; i++) lane_data[i] = WIDTH'($urandom);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("rd_onehot0", 32'($onehot0(bus.rd_o)), 32'd1);
      if (!bus.busy_o) check("rd_idle_zero", 32'(bus.rd_o), 32'd0);
      if (bus.rd_o != '0) begin
        rd_log.push_back(32'(bus.rd_o));
        rd_cyc.push_back(cyc);
      end
      if (bus.valid_o && !bus.ready_i) begin
        stall_cnt++;
        check("rd_stall_zero", 32'(bus.rd_o), 32'd0);
      end
      if (prev_stall) begin
        check("hold_valid", 32'(bus.valid_o), 32'd1);
        check("hold_idx", 32'(bus.idx_o), 32'(prev_idx));
        check("hold_data", 32'(bus.data_o), 32'(prev_data));
      end
      if (bus.valid_o && bus.ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word_idx", 32'(bus.idx_o), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("word_idx", 32'(bus.idx_o), mon_e.idx);
          check("word_data", 32'(bus.data_o), mon_e.data);
        end
        xfer_cyc.push_back(cyc);
      end
      if (bus.done_o) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_single_cycle", 32'(prev_done), 32'd0);
      end
      prev_stall = bus.valid_o && !bus.ready_i;
      prev_done  = bus.done_o;
      prev_data  = bus.data_o;
      prev_idx   = bus.idx_o;
    end else begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int d0;
    logic [NUM-1:0] m;

    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    bus.mask_i  = '0;
    bus.ready_i = 1'b1;
    for (int i = 0; i < NUM; i++) lane_data[i] = WIDTH'(i + 3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rd", 32'(bus.rd_o), 32'd0);
    check("rst_data", 32'(bus.data_o), 32'd0);
    check("rst_idx", 32'(bus.idx_o), 32'd0);
    check("rst_valid", 32'(bus.valid_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // A5 at full rate: lanes 0,2,5,7 back to back, done right after the last word.
    clear_logs();
    expect_scan(8'hA5);
    do_start(8'hA5, p);
    wait_done(1'b0);
    check("a5_words", 32'(xfer_cyc.size()), 32'd4);
    if (xfer_cyc.size() == 4) begin
      check("a5_first_word_cyc", 32'(xfer_cyc[0]), 32'(p + 2));
      check("a5_last_word_cyc", 32'(xfer_cyc[3]), 32'(p + 5));
    end
    check("a5_done_cyc", 32'(done_cyc), 32'(p + 6));
    check("a5_rd_beats", 32'(rd_log.size()), 32'd4);
    if (rd_log.size() == 4) begin
      check("a5_rd0", rd_log[0], 32'h01);
      check("a5_rd1", rd_log[1], 32'h04);
      check("a5_rd2", rd_log[2], 32'h20);
      check("a5_rd3", rd_log[3], 32'h80);
      check("a5_rd_first_cyc", 32'(rd_cyc[0]), 32'(p + 1));
      check("a5_rd_last_cyc", 32'(rd_cyc[3]), 32'(p + 4));
    end
    check("a5_busy_after", 32'(bus.busy_o), 32'd0);

    // FF with a three-cycle stall on the second word.
    clear_logs();
    set_lanes_random();
    expect_scan(8'hFF);
    do_start(8'hFF, p);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    bus.ready_i = 1'b1;
    wait_done(1'b0);
    check("ff_stall_cycles", 32'(stall_cnt), 32'd3);
    check("ff_words", 32'(xfer_cyc.size()), 32'd8);

    // Empty mask: no words, done two cycles after start.
    clear_logs();
    expect_scan('0);
    do_start('0, p);
    wait_done(1'b0);
    check("empty_done_cyc", 32'(done_cyc), 32'(p + 2));
    check("empty_words", 32'(xfer_cyc.size()), 32'd0);
    check("empty_rd", 32'(rd_log.size()), 32'd0);

    // Start pulsed mid-scan must be ignored.
    clear_logs();
    d0 = done_cnt;
    expect_scan(8'h80);
    do_start(8'h80, p);
    bus.start_i = 1'b1;
    bus.mask_i  = 8'h03;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    wait_done(1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("ignore_start_done", 32'(done_cnt - d0), 32'd1);
    check("ignore_start_words", 32'(xfer_cyc.size()), 32'd1);
    check("ignore_start_busy", 32'(bus.busy_o), 32'd0);

    // Reset during the second word of 0F clears everything, no done.
    clear_logs();
    d0 = done_cnt;
    expect_scan(8'h0F);
    do_start(8'h0F, p);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd", 32'(bus.rd_o), 32'd0);
    check("mid_rst_data", 32'(bus.data_o), 32'd0);
    check("mid_rst_idx", 32'(bus.idx_o), 32'd0);
    check("mid_rst_valid", 32'(bus.valid_o), 32'd0);
    check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    check("mid_rst_done", 32'(bus.done_o), 32'd0);
    exp_q.delete();
    exp_done--;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    clear_logs();
    expect_scan(8'h10);
    do_start(8'h10, p);
    wait_done(1'b0);
    check("post_rst_words", 32'(xfer_cyc.size()), 32'd1);

    // start_i held high: back-to-back scans of lane 7.
    clear_logs();
    d0 = done_cnt;
    bus.mask_i  = 8'h80;
    bus.start_i = 1'b1;
    expect_scan(8'h80);
    for (int s = 0; s < 4; s++) begin
      bit found = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (bus.done_o) begin
          found = 1'b1;
          break;
        end
      end
      if (!found) check("held_done_timeout", 32'd0, 32'd1);
      if (s < 3) expect_scan(8'h80);
      else bus.start_i = 1'b0;
    end
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    check("held_done_count", 32'(done_cnt - d0), 32'd4);
    check("held_words", 32'(xfer_cyc.size()), 32'd4);
    check("held_busy_after", 32'(bus.busy_o), 32'd0);

    // Randomized scans with random backpressure and stray starts.
    for (int t = 0; t < 40; t++) begin
      set_lanes_random();
      m = NUM'($urandom);
      if ($urandom_range(0, 7) == 0) m = '0;
      expect_scan(m);
      do_start(m, p);
      if ($urandom_range(0, 1) == 1) begin
        bus.start_i = 1'b1;
        bus.mask_i  = NUM'($urandom);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
      end
      wait_done(1'b1);
    end

    repeat (5) begin @(posedge clk); #1; end
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_done_count", 32'(done_cnt), 32'(exp_done));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reduce_rd_sequencer.md
Name: reduce_rd_sequencer

Overview:
Sequencer directly upstream of the reduce-in-datas priority mux in the bin manager. On a start command it walks a lane mask lowest-index-first and drives exactly one one-hot read strobe per beat into the mux's rd_i. It captures the mux's reduced data_o into an output register and streams each captured word downstream over a valid/ready handshake. It sustains one word per cycle when the sink does not stall and signals completion with a done pulse.

Parameters:
NUM, 8, number of lanes; matches the NUM of the mux fed (power of two, 2..8)
WIDTH, 5, data word width; matches the mux WIDTH
IDXW, $clog2(NUM), width of the lane index output

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
start_i  input  1  start a scan; sampled only in IDLE
mask_i  input  NUM  lanes to read; latched when start_i is accepted
rd_o  output  NUM  one-hot read strobe to mux rd_i; all-zero when not reading
data_i  input  WIDTH  reduced data from mux data_o (combinational response to rd_o)
data_o  output  WIDTH  registered captured word
idx_o  output  IDXW  lane index of the word on data_o
valid_o  output  1  data_o/idx_o valid
ready_i  input  1  downstream accepts when valid_o && ready_i
busy_o  output  1  high while in RUN
done_o  output  1  one-cycle pulse after the scan completes

Behaviour:
- Reset (async assert, sync-free release): state=IDLE, pending=0, data_o=0, idx_o=0, valid_o=0, done_o=0, busy_o=0; rd_o=0 combinationally.
- States: IDLE, RUN.
- IDLE: when start_i=1, pending<=mask_i and state<=RUN. done_o<=0. rd_o=0.
- RUN, combinational read: can_load = !valid_o || ready_i; rd_o = (can_load && pending!=0) ? lowest set bit of pending : 0.
- RUN, on clock edge with rd_o!=0: data_o<=data_i, idx_o<=index of rd_o bit, valid_o<=1, and the corresponding pending bit is cleared.
- RUN, on clock edge with rd_o==0 and valid_o&&ready_i: valid_o<=0.
- Completion: on the edge where pending==0 and (!valid_o || ready_i), state<=IDLE, valid_o<=0, and done_o<=1 for exactly one cycle.
- Latency: start sampled at edge N; first rd_o in cycle N+1; word valid in cycle N+2. Throughput is 1 word/cycle while ready_i=1.
- Backpressure: while valid_o=1 and ready_i=0, rd_o=0 and data_o/idx_o/valid_o are held stable. No word is lost or duplicated.
- Empty mask: start with mask_i=0 enters RUN for one cycle with rd_o=0, then returns to IDLE with a done_o pulse. No valid_o.
- start_i while busy is ignored and mask_i is not re-latched. start_i in the same cycle done_o is high is accepted (state is IDLE).
- rd_o is never multi-hot and is never nonzero outside RUN.
- Reset mid-scan: all state is cleared immediately. rd_o drops to 0 and no done_o pulse is produced.
- busy_o = (state==RUN).

Test Plan:
- mask_i=8'hA5, ready_i=1, data_i=lane-index+3 model → rd_o=01,04,20,80 in four consecutive cycles. Outputs (idx,data)=(0,3),(2,5),(5,8),(7,10) on consecutive cycles. done_o pulses one cycle after the last word; busy_o then 0.
- mask_i=8'hFF, ready_i low for 3 cycles at the second word → idx_o=1 and its data are held stable over the 3 stall cycles, rd_o=0 during the stall. Total of 8 words, no duplicates, in index order 0..7.
- mask_i=0 → no valid_o, rd_o stays 0, done_o=1 exactly once, 2 cycles after start.
- start_i pulsed with mask 8'h03 during a scan of 8'h80 → only idx 7 is emitted, one done_o.
- rst_n asserted during the second word of 8'h0F → all outputs are 0 immediately. After release, start with 8'h10 emits only idx 4.
- mask_i=8'h80 with start_i held high continuously → repeated scans each emit idx 7 followed by done_o. The scoreboard confirms rd_o is one-hot or zero every cycle.
